// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   state_e   : transmitter FSM states
//   PAR_*     : parity mode encodings for the PARITY parameter
//   calc_div  : clock cycles per bit, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   restart  : synchronously clears the count (frame load / idle)
//   bit_tick : high on the last cycle (count DIV-1) of each bit period
module uart_baud_gen #(
  parameter int DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Depends only on the register, so restart (which depends on the tick
  // through the pop decision) cannot form a combinational loop.
  assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with an input FIFO.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   data       : payload word (DATA_BITS wide)
//   valid      : producer presents data
//   ready      : FIFO can accept; transfer on valid && ready
//   tx         : registered serial output, idle high
//   busy       : frame in flight or FIFO non-empty
//   fifo_count : words currently held in the FIFO
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [AW:0] DEPTH_V   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_cfg: illegal parameter combination");
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, rptr_q;
  logic [AW:0]          count;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;

  assign count = wptr_q - rptr_q;
  assign full  = (count == DEPTH_V);
  assign empty = (count == '0);
  // Refused when full even if a pop happens this cycle: no pass-through.
  assign push  = valid && !full;
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // ----------------------------------------------------------------- FSM
  state_e               state_q, state_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_tick, restart;

  // Counter held in IDLE and realigned on every frame load.
  assign restart = pop || (state_q == IDLE);

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          shreg_d = head;
          par_d   = (PARITY == PAR_ODD) ? ~^head : ^head;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shreg_d = shreg_q >> 1;
          if (bitcnt_q == LAST_DATA) begin
            state_d  = (PARITY != PAR_NONE) ? PAR : STOP;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (bit_tick) begin
          state_d  = STOP;
          bitcnt_d = '0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bitcnt_q == LAST_STOP) begin
            // Back-to-back: reload directly from the FIFO, no idle cycle.
            if (!empty) begin
              pop     = 1'b1;
              state_d = START;
              shreg_d = head;
              par_d   = (PARITY == PAR_ODD) ? ~^head : ^head;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered, so its next value follows the next state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign ready      = !full;
  assign fifo_count = count;
  assign busy       = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

  localparam int CLKF  = 1000;
  localparam int BAUDR = 100;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int NI    = 4;

  // Per-instance configuration: 8N1, 8E1, 8O2, 7N1
  int db_c  [NI] = '{8, 8, 8, 7};
  int par_c [NI] = '{0, 2, 1, 0};
  int sb_c  [NI] = '{1, 1, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_v [NI];
  logic [8:0] data_v  [NI];
  logic       tx_w    [NI];
  logic       busy_w  [NI];
  logic       ready_w [NI];
  logic [2:0] cnt_w   [NI];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .data(data_v[0][7:0]), .valid(valid_v[0]),
    .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_cfg #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .data(data_v[1][7:0]), .valid(valid_v[1]),
    .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));

  uart_tx_cfg #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_8o2 (
    .clk(clk), .rst_n(rst_n), .data(data_v[2][7:0]), .valid(valid_v[2]),
    .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));

  uart_tx_cfg #(.CLK_FREQ(CLKF), .BAUD(BAUDR), .DATA_BITS(7), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_7n1 (
    .clk(clk), .rst_n(rst_n), .data(data_v[3][6:0]), .valid(valid_v[3]),
    .ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

  // ------------------------------------------------ reference model
  // Each accepted word becomes a frame with an acceptance edge, a start
  // edge and a bit list; all outputs are derived from that list.
  typedef struct {
    int          inst;
    int          acc;
    int          st;
    int          len;
    logic [15:0] bits;
  } frm_t;

  typedef struct {
    int         inst;
    logic [8:0] w;
  } req_t;

  frm_t fq[$];
  req_t sq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   gap_mode = 1'b0;

  function automatic int last_end(int i);
    int e = 0;
    foreach (fq[k])
      if (fq[k].inst == i && fq[k].st + fq[k].len > e) e = fq[k].st + fq[k].len;
    return e;
  endfunction

  function automatic int m_count(int i, int t);
    int n = 0;
    foreach (fq[k])
      if (fq[k].inst == i && fq[k].acc <= t && t < fq[k].st) n++;
    return n;
  endfunction

  function automatic logic m_busy(int i, int t);
    logic b = 1'b0;
    foreach (fq[k])
      if (fq[k].inst == i && fq[k].acc <= t && t < fq[k].st + fq[k].len) b = 1'b1;
    return b;
  endfunction

  function automatic logic m_tx(int i, int t);
    logic r = 1'b1;
    foreach (fq[k])
      if (fq[k].inst == i && fq[k].st <= t && t < fq[k].st + fq[k].len)
        r = fq[k].bits[(t - fq[k].st) / DIV];
    return r;
  endfunction

  function automatic int find_req(int i);
    foreach (sq[k]) if (sq[k].inst == i) return k;
    return -1;
  endfunction

  task automatic add_frame(int i, logic [8:0] w, int acc);
    frm_t f;
    int   n;
    int   ones = 0;
    int   le;
    f.inst    = i;
    f.acc     = acc;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int k = 0; k < db_c[i]; k++) begin
      f.bits[1 + k] = w[k];
      ones += int'(w[k]);
    end
    n = 1 + db_c[i];
    if (par_c[i] != 0) begin
      // even: parity bit makes total ones even; odd: makes it odd
      f.bits[n] = (par_c[i] == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    n += sb_c[i];
    f.len = n * DIV;
    le    = last_end(i);
    f.st  = (acc + 1 > le) ? acc + 1 : le;
    fq.push_back(f);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enq(int i, logic [8:0] w);
    req_t r;
    r.inst = i;
    r.w    = w;
    sq.push_back(r);
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      int idx = find_req(i);
      logic g = gap_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      valid_v[i] = (idx >= 0) && g;
      data_v[i]  = (idx >= 0) ? sq[idx].w : 9'd0;
    end
  endtask

  task automatic step();
    bit acc [NI];
    for (int i = 0; i < NI; i++)
      acc[i] = rst_n && valid_v[i] && (m_count(i, cyc) < DEPTH);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (acc[i]) begin
        int idx = find_req(i);
        add_frame(i, data_v[i], cyc);
        if (idx >= 0) sq.delete(idx);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("tx[%0d]@%0d", i, cyc), tx_w[i], m_tx(i, cyc));
      chk($sformatf("busy[%0d]@%0d", i, cyc), busy_w[i], m_busy(i, cyc));
      chk($sformatf("count[%0d]@%0d", i, cyc), cnt_w[i], m_count(i, cyc));
      chk($sformatf("ready[%0d]@%0d", i, cyc), ready_w[i], m_count(i, cyc) < DEPTH);
    end
    drive();
  endtask

  function automatic bit pending();
    bit p = (sq.size() != 0);
    for (int i = 0; i < NI; i++) if (m_busy(i, cyc)) p = 1'b1;
    return p;
  endfunction

  task automatic run_idle(int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("drain@%0d", cyc), pending(), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int target;
    int guard;

    for (int i = 0; i < NI; i++) begin
      valid_v[i] = 1'b0;
      data_v[i]  = '0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_tx[%0d]", i), tx_w[i], 1);
      chk($sformatf("rst_busy[%0d]", i), busy_w[i], 0);
      chk($sformatf("rst_ready[%0d]", i), ready_w[i], 1);
      chk($sformatf("rst_count[%0d]", i), cnt_w[i], 0);
    end
    rst_n = 1'b1;

    // Directed single frames: 0x41 on the 8-bit variants, 0x55 on 7N1
    enq(0, 9'h041); enq(1, 9'h041); enq(2, 9'h041); enq(3, 9'h055);
    drive();
    repeat (140) step();

    // Six words with valid held high on the 8N1 instance
    for (int k = 1; k <= 6; k++) enq(0, 9'(k));
    drive();
    run_idle(1000);

    // Random bursts, alternating continuous and gapped valid
    for (int r = 0; r < 6; r++) begin
      gap_mode = (r % 2) == 1;
      for (int i = 0; i < NI; i++) begin
        int nw = $urandom_range(0, 6);
        for (int k = 0; k < nw; k++) enq(i, 9'($urandom_range(0, 511)));
      end
      drive();
      run_idle(4000);
      repeat ($urandom_range(0, 15)) step();
    end
    gap_mode = 1'b0;

    // Push on the exact edge the last queued word is popped from STOP
    n0 = fq.size();
    enq(0, 9'($urandom_range(0, 255)));
    enq(0, 9'($urandom_range(0, 255)));
    drive();
    step();
    step();
    target = fq[n0].st + fq[n0].len - 1;
    guard = 0;
    while (cyc < target && guard < 500) begin
      step();
      guard++;
    end
    enq(0, 9'($urandom_range(0, 255)));
    drive();
    step();
    chk("pushpop_count", cnt_w[0], 1);
    run_idle(600);

    // Asynchronous reset in the middle of the data bits, two words queued
    enq(0, 9'($urandom_range(0, 255)));
    enq(0, 9'($urandom_range(0, 255)));
    enq(0, 9'($urandom_range(0, 255)));
    for (int i = 1; i < NI; i++) enq(i, 9'($urandom_range(0, 511)));
    drive();
    repeat (40) step();
    chk("pre_rst_count", cnt_w[0], 2);
    #2;
    rst_n = 1'b0;
    sq.delete();
    fq.delete();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("arst_tx[%0d]", i), tx_w[i], 1);
      chk($sformatf("arst_busy[%0d]", i), busy_w[i], 0);
      chk($sformatf("arst_count[%0d]", i), cnt_w[i], 0);
      chk($sformatf("arst_ready[%0d]", i), ready_w[i], 1);
    end
    drive();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (150) step();
    enq(0, 9'($urandom_range(0, 255)));
    drive();
    run_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
